// File: rtl/cache_miss_handler_pkg.sv
// Shared definitions for the cache miss handler: default widths and FSM state encoding.
package cache_miss_handler_pkg;

    localparam int unsigned DefAddrWidth = 8;
    localparam int unsigned DefDataWidth = 8;
    // Narrowest timeout counter width; wider only when the timeout needs it.
    localparam int unsigned MinTimerWidth = 8;

    // IDLE must stay at zero so the reset state decodes as all-zero.
    typedef enum logic [3:0] {
        StIdle    = 4'd0,
        StLookup  = 4'd1,
        StCheck   = 4'd2,
        StMemrd   = 4'd3,
        StFill    = 4'd4,
        StCwrite  = 4'd5,
        StCsettle = 4'd6,
        StMemwr   = 4'd7,
        StSettle  = 4'd8,
        StDone    = 4'd9
    } state_e;

    // True in the states that hold mem_req high.
    function automatic logic is_mem_state(input state_e s);
        return (s == StMemrd) || (s == StMemwr);
    endfunction

    // Width of the timeout counter for a given timeout value.
    function automatic int unsigned timer_width(input int unsigned timeout);
        int unsigned w;
        w = $clog2(timeout + 1);
        return (w > MinTimerWidth) ? w : MinTimerWidth;
    endfunction

endpackage

// File: rtl/cache_miss_handler_mem_timer.sv
// Memory-access watchdog: loadable down-counter that flags the last allowed wait cycle.
module cache_miss_handler_mem_timer #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned LOAD_VALUE = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic clr,
    input  logic dec,
    output logic expired
);

    logic [WIDTH-1:0] count_q;

    // Counter register: clear has priority, then load, then decrement down to zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= WIDTH'(LOAD_VALUE);
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    // A count of one means this is the final cycle the requester may wait.
    assign expired = (count_q == WIDTH'(1));

endmodule

// File: rtl/cache_miss_handler.sv
// Requester-side controller for the LRU data cache: load lookup, miss fill from memory and
// write-through stores, with a watchdog on every memory access.
module cache_miss_handler
    import cache_miss_handler_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = DefAddrWidth,
    parameter int unsigned DATA_WIDTH  = DefDataWidth,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    // CPU side
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  req_ready,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err,
    // Cache side
    output logic                  cache_we,
    output logic [ADDR_WIDTH-1:0] cache_addr,
    output logic [DATA_WIDTH-1:0] cache_wdata,
    input  logic [DATA_WIDTH-1:0] cache_rdata,
    input  logic                  cache_hit,
    // Memory side
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [DATA_WIDTH-1:0] MissData   = {DATA_WIDTH{1'b1}};
    localparam int unsigned           TimerWidth = timer_width(MEM_TIMEOUT);

    state_e state_q, state_d;

    // Request latches and the word/error reported in DONE.
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  err_q, err_d;

    logic timer_load, timer_clr, timer_dec, timer_expired;
    logic accept;

    // req_ready is a register that mirrors state IDLE, so this is a true handshake.
    assign accept = req_valid && req_ready;

    // Watchdog restarts on every entry to a memory-wait state and is idle otherwise.
    assign timer_load = is_mem_state(state_d) && !is_mem_state(state_q);
    assign timer_dec  = is_mem_state(state_q);
    assign timer_clr  = (state_q == StIdle);

    cache_miss_handler_mem_timer #(
        .WIDTH      (TimerWidth),
        .LOAD_VALUE (MEM_TIMEOUT)
    ) u_mem_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (timer_load),
        .clr     (timer_clr),
        .dec     (timer_dec),
        .expired (timer_expired)
    );

    // Next-state and datapath-latch logic.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        data_d  = data_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    data_d  = '0;
                    err_d   = 1'b0;
                    state_d = req_we ? StCwrite : StLookup;
                end
            end
            StLookup: state_d = StCheck;
            StCheck: begin
                if (cache_hit) begin
                    data_d  = cache_rdata;
                    state_d = StSettle;
                end else begin
                    state_d = StMemrd;
                end
            end
            StMemrd: begin
                // An ack in the expiry cycle still counts as a good read.
                if (mem_ack) begin
                    data_d  = mem_rdata;
                    state_d = StFill;
                end else if (timer_expired) begin
                    data_d  = MissData;
                    err_d   = 1'b1;
                    state_d = StDone;
                end
            end
            StFill:    state_d = StSettle;
            StCwrite:  state_d = StCsettle;
            StCsettle: state_d = StMemwr;
            StMemwr: begin
                if (mem_ack) begin
                    state_d = StDone;
                end else if (timer_expired) begin
                    data_d  = MissData;
                    err_d   = 1'b1;
                    state_d = StDone;
                end
            end
            StSettle: state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // State and datapath latches.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // Moore outputs, registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
            cache_we    <= 1'b0;
            cache_addr  <= '0;
            cache_wdata <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
        end else begin
            req_ready   <= (state_d == StIdle);
            rsp_valid   <= (state_d == StDone);
            rsp_data    <= (state_d == StDone) ? data_d : '0;
            rsp_err     <= (state_d == StDone) && err_d;
            cache_we    <= (state_d == StFill) || (state_d == StCwrite);
            cache_addr  <= addr_d;
            cache_wdata <= (state_d == StFill)   ? data_d  :
                           (state_d == StCwrite) ? wdata_d : '0;
            mem_req     <= is_mem_state(state_d);
            mem_we      <= (state_d == StMemwr);
            mem_addr    <= addr_d;
            mem_wdata   <= (state_d == StMemwr) ? wdata_d : '0;
        end
    end

    // we_q is kept for observability of the latched request type.
    logic unused_we;
    assign unused_we = we_q;

endmodule

// File: tb/tb_cache_miss_handler.sv
// Scoreboard bench: the driver pushes expected responses, a monitor pops them on rsp_valid.
// Pairs the handler with a 4-cell LRU cache model and a memory with programmable ack delay.
module tb_cache_miss_handler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_valid = 1'b0, req_we = 1'b0;
    logic [7:0] req_addr = '0, req_wdata = '0;
    logic       req_ready, rsp_valid, rsp_err;
    logic [7:0] rsp_data;
    logic       cache_we, cache_hit = 1'b0;
    logic [7:0] cache_addr, cache_wdata, cache_rdata = '0;
    logic       mem_req, mem_we, mem_ack;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;

    cache_miss_handler #(
        .ADDR_WIDTH  (8),
        .DATA_WIDTH  (8),
        .MEM_TIMEOUT (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .cache_we    (cache_we),
        .cache_addr  (cache_addr),
        .cache_wdata (cache_wdata),
        .cache_rdata (cache_rdata),
        .cache_hit   (cache_hit),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    // Latency is counted inclusively from the accept cycle to the rsp_valid cycle.
    typedef struct {
        logic [7:0] data;
        logic       err;
        int         lat;
        int         acc;
    } exp_t;
    exp_t sb[$];

    int checks = 0, failures = 0, cyc = 0;
    int rsp_cnt = 0, acc_cnt = 0, mreq_cyc = 0, we_cnt = 0;
    logic prev_we = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory model: ack in the ack_delay-th cycle of mem_req, never when ack_never is set.
    logic [7:0] mem [256];
    int         ack_delay = 3;
    bit         ack_never = 1'b0;
    int         req_age = 0;
    int         wr_cnt = 0;
    logic [7:0] wr_addr = '0, wr_data = '0;

    assign mem_ack   = mem_req && !ack_never && (req_age == ack_delay - 1);
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        req_age <= mem_req ? req_age + 1 : 0;
        if (mem_ack && mem_we) begin
            mem[mem_addr] <= mem_wdata;
            wr_addr       <= mem_addr;
            wr_data       <= mem_wdata;
            wr_cnt        <= wr_cnt + 1;
        end
    end

    // 4-cell LRU cache model, entry 0 is most recent; hit/rdata registered from cache_addr.
    logic [7:0] c_tag [4];
    logic [7:0] c_dat [4];
    logic       c_vld [4];
    int         c_idx, c_pos;

    function automatic int find(input logic [7:0] a);
        for (int i = 0; i < 4; i++) if (c_vld[i] && c_tag[i] == a) return i;
        return -1;
    endfunction

    initial begin
        for (int i = 0; i < 4; i++) begin
            c_tag[i] = '0; c_dat[i] = '0; c_vld[i] = 1'b0;
        end
        forever begin
            @(posedge clk);
            c_idx = find(cache_addr);
            cache_hit   <= (c_idx >= 0);
            cache_rdata <= (c_idx >= 0) ? c_dat[c_idx] : 8'h00;
            if (cache_we) begin
                c_pos = (c_idx >= 0) ? c_idx : 3;
                for (int i = c_pos; i > 0; i--) begin
                    c_tag[i] = c_tag[i-1]; c_dat[i] = c_dat[i-1]; c_vld[i] = c_vld[i-1];
                end
                c_tag[0] = cache_addr; c_dat[0] = cache_wdata; c_vld[0] = 1'b1;
            end
        end
    end

    // Monitor: scoreboard pop on rsp_valid plus per-cycle bus invariants.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (rsp_valid) begin
                    rsp_cnt++;
                    if (sb.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_rsp: got data 0x%0h with empty scoreboard", rsp_data);
                    end else begin
                        e = sb.pop_front();
                        check("rsp_data", int'(rsp_data), int'(e.data));
                        check("rsp_err", int'(rsp_err), int'(e.err));
                        if (e.lat > 0) check("latency", cyc - e.acc + 2, e.lat);
                    end
                end
                if (mem_req) begin
                    mreq_cyc++;
                    check("mem_addr_eq_cache_addr", int'(mem_addr), int'(cache_addr));
                end
                if (cache_we) begin
                    we_cnt++;
                    check("cache_we_not_consecutive", int'(prev_we), 0);
                end
                prev_we = cache_we;
                if (req_valid && req_ready) acc_cnt++;
            end
        end
    end

    // Present a request, wait for the accept edge and push the expected response.
    task automatic issue(input logic we, input logic [7:0] addr, input logic [7:0] wd,
                         input logic [7:0] exp_data, input logic exp_err, input int exp_lat,
                         input bit hold);
        int n;
        exp_t e;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 200);
        if (!req_ready) begin
            checks++; failures++;
            $display("FAIL accept_timeout: req_ready 0 after %0d cycles, required 1", n);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        mreq_cyc = 0; we_cnt = 0;
        e.data = exp_data; e.err = exp_err; e.lat = exp_lat; e.acc = cyc;
        sb.push_back(e);
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target);
        int n;
        n = 0;
        while (rsp_cnt < target && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("rsp_arrived", int'(rsp_cnt >= target), 1);
    endtask

    initial begin
        int acc0, rsp0, n;
        logic [7:0] hold_exp [5];
        for (int i = 0; i < 256; i++) mem[i] = ~8'(i);
        mem[8'h10] = 8'hA5;
        hold_exp[0] = 8'hBF; hold_exp[1] = 8'hBE; hold_exp[2] = 8'hBD;
        hold_exp[3] = 8'hBC; hold_exp[4] = 8'hBB;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_req_ready", int'(req_ready), 1);
        check("reset_rsp_valid", int'(rsp_valid), 0);
        check("reset_rsp_data", int'(rsp_data), 0);
        check("reset_mem_req", int'(mem_req), 0);
        check("reset_cache_we", int'(cache_we), 0);
        check("reset_cache_addr", int'(cache_addr), 0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;

        // Cold load with ack delay 3: 6 + 3 cycles, one fill pulse
        issue(1'b0, 8'h10, 8'h00, 8'hA5, 1'b0, 9, 1'b0);
        wait_rsp(1);
        check("t1_mem_req_cycles", mreq_cyc, 3);
        check("t1_fill_pulses", we_cnt, 1);

        // Repeat load hits: 5 cycles, no memory traffic
        issue(1'b0, 8'h10, 8'h00, 8'hA5, 1'b0, 5, 1'b0);
        wait_rsp(2);
        check("t2_mem_req_cycles", mreq_cyc, 0);
        check("t2_cache_we", we_cnt, 0);

        // Write-through store, then a hitting load of the stored word
        issue(1'b1, 8'h20, 8'h3C, 8'h00, 1'b0, -1, 1'b0);
        wait_rsp(3);
        check("t3_cache_we_pulses", we_cnt, 1);
        check("t3_mem_req_cycles", mreq_cyc, 3);
        check("t3_mem_writes", wr_cnt, 1);
        check("t3_mem_wr_addr", int'(wr_addr), 8'h20);
        check("t3_mem_wr_data", int'(wr_data), 8'h3C);
        issue(1'b0, 8'h20, 8'h00, 8'h3C, 1'b0, 5, 1'b0);
        wait_rsp(4);
        check("t3_load_mem_req_cycles", mreq_cyc, 0);

        // Timeout: no ack, mem_req for exactly MEM_TIMEOUT cycles, error response, no fill
        ack_never = 1'b1;
        issue(1'b0, 8'h30, 8'h00, 8'hFF, 1'b1, -1, 1'b0);
        wait_rsp(5);
        check("t4_mem_req_cycles", mreq_cyc, 4);
        check("t4_no_fill", we_cnt, 0);
        ack_never = 1'b0;
        issue(1'b0, 8'h30, 8'h00, 8'hCF, 1'b0, 9, 1'b0);
        wait_rsp(6);
        check("t4_reload_misses", mreq_cyc, 3);

        // Ack in the expiry cycle wins over the timeout
        ack_delay = 4;
        issue(1'b0, 8'h60, 8'h00, 8'h9F, 1'b0, 10, 1'b0);
        wait_rsp(7);
        check("ack_at_expiry_mem_req_cycles", mreq_cyc, 4);
        ack_delay = 3;

        // Reset during MEMRD aborts without a response
        ack_never = 1'b1;
        issue(1'b0, 8'h50, 8'h00, 8'hAF, 1'b0, -1, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_req && n < 50);
        check("t5_reached_memrd", int'(mem_req), 1);
        rsp0 = rsp_cnt;
        #2 rst = 1'b0;
        #1;
        check("t5_mem_req_drops", int'(mem_req), 0);
        check("t5_req_ready_idle", int'(req_ready), 1);
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        ack_never = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("t5_no_rsp_after_abort", rsp_cnt, rsp0);
        issue(1'b0, 8'h50, 8'h00, 8'hAF, 1'b0, 9, 1'b0);
        wait_rsp(rsp0 + 1);

        // Continuous req_valid across five new addresses; the first is then evicted
        acc0 = acc_cnt;
        rsp0 = rsp_cnt;
        for (int i = 0; i < 5; i++)
            issue(1'b0, 8'h40 + 8'(i), 8'h00, hold_exp[i], 1'b0, -1, i < 4);
        wait_rsp(rsp0 + 5);
        check("t6_accepts", acc_cnt - acc0, 5);
        check("t6_responses", rsp_cnt - rsp0, 5);
        issue(1'b0, 8'h44, 8'h00, 8'hBB, 1'b0, 5, 1'b0);
        wait_rsp(rsp0 + 6);
        check("t6_recent_hits", mreq_cyc, 0);
        issue(1'b0, 8'h40, 8'h00, 8'hBF, 1'b0, 9, 1'b0);
        wait_rsp(rsp0 + 7);
        check("t6_evicted_misses", mreq_cyc, 3);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
